// File: rtl/mimo_backsub_seq_if.sv
// Load, divider and result bus of the back-substitution engine.
// The engine connects through the slave modport; its environment uses master.
interface mimo_backsub_seq_if #(
    parameter int W = 28
);
    logic           wr_en;
    logic [3:0]     wr_addr;
    logic [W-1:0]   wr_real;
    logic [W-1:0]   wr_imag;
    logic           start;
    logic           busy;
    logic           div_req;
    logic [W-1:0]   div_num_real;
    logic [W-1:0]   div_num_imag;
    logic [W-1:0]   div_den_real;
    logic [W-1:0]   div_den_imag;
    logic           div_ack;
    logic [W-1:0]   div_q_real;
    logic [W-1:0]   div_q_imag;
    logic           x_valid;
    logic           x_ready;
    logic [4*W-1:0] x_real;
    logic [4*W-1:0] x_imag;
    logic           err;

    modport master (
        output wr_en, wr_addr, wr_real, wr_imag, start,
        output div_ack, div_q_real, div_q_imag, x_ready,
        input  busy, div_req, div_num_real, div_num_imag, div_den_real, div_den_imag,
        input  x_valid, x_real, x_imag, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_real, wr_imag, start,
        input  div_ack, div_q_real, div_q_imag, x_ready,
        output busy, div_req, div_num_real, div_num_imag, div_den_real, div_den_imag,
        output x_valid, x_real, x_imag, err
    );
endinterface

// File: rtl/mimo_backsub_seq.sv
// Sequenced back-substitution for a 4x4 upper-triangular R: x4 first, x1 last,
// one shared complex multiplier and an external iterative divider.
module mimo_backsub_seq #(
    parameter int W    = 28,
    parameter int FRAC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mimo_backsub_seq_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        MAC  = 3'd2,
        DIV  = 3'd3,
        OUT  = 3'd4
    } state_t;

    // Packed storage address of R(row,col), zero-based, col >= row.
    function automatic logic [3:0] r_index(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] base;
        case (row)
            2'd0:    base = 4'd0;
            2'd1:    base = 4'd4;
            2'd2:    base = 4'd7;
            2'd3:    base = 4'd9;
            default: base = 4'd0;
        endcase
        return base + {2'b00, col} - {2'b00, row};
    endfunction

    // Full-precision complex product, arithmetic shift by FRAC, wrapped to W bits; {re, im}.
    function automatic logic [2*W-1:0] cmul_q(input logic signed [W-1:0] ar, input logic signed [W-1:0] ai,
                                              input logic signed [W-1:0] br, input logic signed [W-1:0] bi);
        logic signed [2*W:0] arx, aix, brx, bix, pr, pi;
        arx = {{(W+1){ar[W-1]}}, ar};
        aix = {{(W+1){ai[W-1]}}, ai};
        brx = {{(W+1){br[W-1]}}, br};
        bix = {{(W+1){bi[W-1]}}, bi};
        pr  = (arx * brx - aix * bix) >>> FRAC;
        pi  = (arx * bix + aix * brx) >>> FRAC;
        return {pr[W-1:0], pi[W-1:0]};
    endfunction

    state_t              state_r;
    logic signed [W-1:0] r_re_r  [10];
    logic signed [W-1:0] r_im_r  [10];
    logic signed [W-1:0] yq_re_r [4];
    logic signed [W-1:0] yq_im_r [4];
    logic signed [W-1:0] x_re_r  [4];
    logic signed [W-1:0] x_im_r  [4];
    logic signed [W-1:0] acc_re_r, acc_im_r, den_re_r, den_im_r;
    logic [1:0]          row_r, col_r;
    logic                busy_r, div_req_r, x_valid_r, err_r;

    logic [3:0]          diag_idx_s, mac_idx_s;
    logic                diag_zero_s;
    logic [2*W-1:0]      prod_s;
    logic signed [W-1:0] acc_re_next_s, acc_im_next_s;

    // Diagonal lookup and the multiply-accumulate datapath for the current row/column.
    always_comb begin
        diag_idx_s    = r_index(row_r, row_r);
        mac_idx_s     = r_index(row_r, col_r);
        diag_zero_s   = (r_re_r[diag_idx_s] == {W{1'b0}}) && (r_im_r[diag_idx_s] == {W{1'b0}});
        prod_s        = cmul_q(r_re_r[mac_idx_s], r_im_r[mac_idx_s], x_re_r[col_r], x_im_r[col_r]);
        acc_re_next_s = acc_re_r - prod_s[2*W-1:W];
        acc_im_next_s = acc_im_r - prod_s[W-1:0];
    end

    // Sequencer: loading, per-row accumulate, divider handshake and result hand-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            for (int k = 0; k < 10; k++) begin
                r_re_r[k] <= '0;
                r_im_r[k] <= '0;
            end
            for (int k = 0; k < 4; k++) begin
                yq_re_r[k] <= '0;
                yq_im_r[k] <= '0;
                x_re_r[k]  <= '0;
                x_im_r[k]  <= '0;
            end
            acc_re_r  <= '0;
            acc_im_r  <= '0;
            den_re_r  <= '0;
            den_im_r  <= '0;
            row_r     <= 2'd0;
            col_r     <= 2'd0;
            busy_r    <= 1'b0;
            div_req_r <= 1'b0;
            x_valid_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        for (int k = 0; k < 4; k++) begin
                            x_re_r[k] <= '0;
                            x_im_r[k] <= '0;
                        end
                        err_r   <= 1'b0;
                        row_r   <= 2'd3;
                        busy_r  <= 1'b1;
                        state_r <= INIT;
                    end else if (bus.wr_en) begin
                        if (bus.wr_addr < 4'd10) begin
                            r_re_r[bus.wr_addr] <= bus.wr_real;
                            r_im_r[bus.wr_addr] <= bus.wr_imag;
                        end else if (bus.wr_addr < 4'd14) begin
                            yq_re_r[bus.wr_addr[1:0] - 2'd2] <= bus.wr_real;
                            yq_im_r[bus.wr_addr[1:0] - 2'd2] <= bus.wr_imag;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                INIT: begin
                    acc_re_r <= yq_re_r[row_r];
                    acc_im_r <= yq_im_r[row_r];
                    col_r    <= row_r + 2'd1;
                    if (row_r != 2'd3) begin
                        state_r <= MAC;
                    end else begin
                        den_re_r  <= r_re_r[diag_idx_s];
                        den_im_r  <= r_im_r[diag_idx_s];
                        div_req_r <= ~diag_zero_s;
                        state_r   <= DIV;
                    end
                end
                MAC: begin
                    acc_re_r <= acc_re_next_s;
                    acc_im_r <= acc_im_next_s;
                    if (col_r == 2'd3) begin
                        den_re_r  <= r_re_r[diag_idx_s];
                        den_im_r  <= r_im_r[diag_idx_s];
                        div_req_r <= ~diag_zero_s;
                        state_r   <= DIV;
                    end else begin
                        col_r <= col_r + 2'd1;
                    end
                end
                DIV: begin
                    // No request outstanding here means the diagonal was zero.
                    if (!div_req_r || bus.div_ack) begin
                        if (!div_req_r) begin
                            x_re_r[row_r] <= '0;
                            x_im_r[row_r] <= '0;
                            err_r         <= 1'b1;
                        end else begin
                            x_re_r[row_r] <= bus.div_q_real;
                            x_im_r[row_r] <= bus.div_q_imag;
                            div_req_r     <= 1'b0;
                        end
                        if (row_r == 2'd0) begin
                            x_valid_r <= 1'b1;
                            state_r   <= OUT;
                        end else begin
                            row_r   <= row_r - 2'd1;
                            state_r <= INIT;
                        end
                    end else begin
                        state_r <= DIV;
                    end
                end
                OUT: begin
                    if (bus.x_ready) begin
                        x_valid_r <= 1'b0;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        state_r <= OUT;
                    end
                end
                default: begin
                    div_req_r <= 1'b0;
                    x_valid_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_r;
    assign bus.div_req      = div_req_r;
    assign bus.div_num_real = acc_re_r;
    assign bus.div_num_imag = acc_im_r;
    assign bus.div_den_real = den_re_r;
    assign bus.div_den_imag = den_im_r;
    assign bus.x_valid      = x_valid_r;
    assign bus.x_real       = {x_re_r[3], x_re_r[2], x_re_r[1], x_re_r[0]};
    assign bus.x_imag       = {x_im_r[3], x_im_r[2], x_im_r[1], x_im_r[0]};
    assign bus.err          = err_r;

endmodule

// File: tb/tb_mimo_backsub_seq.sv
// Directed bench for mimo_backsub_seq with an ideal complex divider model
// whose acknowledge delay is programmable per test.
module tb_mimo_backsub_seq;
    localparam int W    = 28;
    localparam int FRAC = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mimo_backsub_seq_if #(.W(W)) bus ();
    mimo_backsub_seq #(.W(W), .FRAC(FRAC)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks  = 0;
    int n_fail    = 0;
    int ack_delay = 0;
    int n_req     = 0;
    int lat;
    logic [W-1:0]   m_re [14];
    logic [W-1:0]   m_im [14];
    logic [4*W-1:0] exp_re, exp_im;

    task automatic check(input string tag, input logic [4*W-1:0] obs, input logic [4*W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [4*W-1:0] pack4(input int a3, input int a2, input int a1, input int a0);
        logic [31:0] v3, v2, v1, v0;
        v3 = a3; v2 = a2; v1 = a1; v0 = a0;
        return {v3[W-1:0], v2[W-1:0], v1[W-1:0], v0[W-1:0]};
    endfunction

    // Ideal complex quotient in Q(FRAC): num * conj(den) / |den|^2.
    function automatic logic [2*W-1:0] ideal_div(input logic [W-1:0] nr, input logic [W-1:0] ni,
                                                 input logic [W-1:0] dr, input logic [W-1:0] di);
        longint a, b, c, d, m, qr, qi;
        logic [63:0] ur, ui;
        a = $signed(nr); b = $signed(ni); c = $signed(dr); d = $signed(di);
        m  = c * c + d * d;
        qr = ((a * c + b * d) * (longint'(1) <<< FRAC)) / m;
        qi = ((b * c - a * d) * (longint'(1) <<< FRAC)) / m;
        ur = qr; ui = qi;
        return {ur[W-1:0], ui[W-1:0]};
    endfunction

    // Divider responder: counts requests, checks operand stability, acks after ack_delay cycles.
    logic         prev_req = 1'b0;
    int           wcnt     = 0;
    logic [W-1:0] num_r_s, num_i_s, den_r_s, den_i_s;
    logic [2*W-1:0] q_s;
    always @(negedge clk) begin
        if (rst) begin
            bus.div_ack = 1'b0;
            wcnt        = 0;
            prev_req    = 1'b0;
        end else begin
            bus.div_ack = 1'b0;
            if (bus.div_req) begin
                if (!prev_req) begin
                    n_req++;
                    num_r_s = bus.div_num_real; num_i_s = bus.div_num_imag;
                    den_r_s = bus.div_den_real; den_i_s = bus.div_den_imag;
                end else begin
                    check("div_num_stable", {bus.div_num_real, bus.div_num_imag}, {num_r_s, num_i_s});
                    check("div_den_stable", {bus.div_den_real, bus.div_den_imag}, {den_r_s, den_i_s});
                end
                if (wcnt == ack_delay) begin
                    q_s            = ideal_div(num_r_s, num_i_s, den_r_s, den_i_s);
                    bus.div_q_real = q_s[2*W-1:W];
                    bus.div_q_imag = q_s[W-1:0];
                    bus.div_ack    = 1'b1;
                end
                wcnt++;
            end else begin
                wcnt = 0;
            end
            prev_req = bus.div_req;
        end
    end

    task automatic load_all();
        for (int a = 0; a < 14; a++) begin
            bus.wr_en = 1'b1; bus.wr_addr = 4'(a); bus.wr_real = m_re[a]; bus.wr_imag = m_im[a];
            @(posedge clk); #1;
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic set_diag();
        for (int a = 0; a < 14; a++) begin
            m_re[a] = '0; m_im[a] = '0;
        end
        m_re[0] = 256; m_re[4] = 256; m_re[7] = 256; m_re[9] = 256;
    endtask

    task automatic set_t2();
        set_diag();
        m_re[1] = 256; m_re[5] = 256; m_re[8] = 256;
        m_re[10] = 512; m_re[11] = 512; m_re[12] = 512; m_re[13] = 256;
    endtask

    // Start a solve; optionally inject start+wr_en(addr 0) at cycle inject_at; returns cycles to x_valid.
    task automatic run_solve(input int inject_at, output int cycles);
        n_req = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1'b1);
        cycles = 0;
        while (!bus.x_valid && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
            bus.start = 1'b0; bus.wr_en = 1'b0;
            if (cycles == inject_at) begin
                bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 4'd0;
                bus.wr_real = 999; bus.wr_imag = 7;
            end
        end
    endtask

    // Hold x_ready low for low_cycles, then complete the output handshake.
    task automatic finish_out(input int low_cycles, input logic [4*W-1:0] ere, input logic [4*W-1:0] eim);
        for (int c = 0; c < low_cycles; c++) begin
            @(posedge clk); #1;
            check("x_valid_held", bus.x_valid, 1'b1);
            check("x_real_held", bus.x_real, ere);
            check("x_imag_held", bus.x_imag, eim);
        end
        bus.x_ready = 1'b1;
        @(posedge clk); #1;
        bus.x_ready = 1'b0;
        check("x_valid_drop", bus.x_valid, 1'b0);
        check("busy_drop", bus.busy, 1'b0);
        check("x_real_kept", bus.x_real, ere);
    endtask

    initial begin
        rst = 1'b1;
        bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_real = '0; bus.wr_imag = '0;
        bus.start = 1'b0; bus.x_ready = 1'b0;
        bus.div_q_real = '0; bus.div_q_imag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_div_req", bus.div_req, 1'b0);
        check("rst_x_valid", bus.x_valid, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_x_real", bus.x_real, '0);
        check("rst_x_imag", bus.x_imag, '0);
        check("rst_div_num", {bus.div_num_real, bus.div_num_imag}, '0);
        check("rst_div_den", {bus.div_den_real, bus.div_den_imag}, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: identity R, x = yq.
        set_diag();
        m_re[10] = 256; m_re[11] = 512; m_re[12] = 768; m_re[13] = 1024;
        load_all();
        run_solve(-1, lat);
        exp_re = pack4(1024, 768, 512, 256);
        check("t1_latency", lat, 14);
        check("t1_req_count", n_req, 4);
        check("t1_x_real", bus.x_real, exp_re);
        check("t1_x_imag", bus.x_imag, '0);
        check("t1_err", bus.err, 1'b0);
        finish_out(0, exp_re, '0);

        // T2: bidiagonal R, every x = 1.0.
        set_t2();
        load_all();
        run_solve(-1, lat);
        exp_re = pack4(256, 256, 256, 256);
        check("t2_latency", lat, 14);
        check("t2_x_real", bus.x_real, exp_re);
        check("t2_x_imag", bus.x_imag, '0);
        check("t2_err", bus.err, 1'b0);
        finish_out(0, exp_re, '0);

        // T3: zero R22 skips one divide and flags err.
        set_diag();
        m_re[4] = 0;
        m_re[10] = 256; m_re[11] = 512; m_re[12] = 768; m_re[13] = 1024;
        load_all();
        run_solve(-1, lat);
        exp_re = pack4(1024, 768, 0, 256);
        check("t3_latency", lat, 14);
        check("t3_req_count", n_req, 3);
        check("t3_x_real", bus.x_real, exp_re);
        check("t3_err", bus.err, 1'b1);
        finish_out(0, exp_re, '0);

        // Imaginary off-diagonal R34 = j1.0 gives x3 = -j1.0.
        set_diag();
        m_im[8] = 256; m_re[13] = 256;
        load_all();
        run_solve(-1, lat);
        exp_re = pack4(256, 0, 0, 0);
        exp_im = pack4(0, -256, 0, 0);
        check("cplx_x_real", bus.x_real, exp_re);
        check("cplx_x_imag", bus.x_imag, exp_im);
        finish_out(0, exp_re, exp_im);

        // T4: slow divider and delayed x_ready.
        set_t2();
        load_all();
        ack_delay = 5;
        run_solve(-1, lat);
        ack_delay = 0;
        exp_re = pack4(256, 256, 256, 256);
        check("t4_latency", lat, 34);
        check("t4_x_real", bus.x_real, exp_re);
        finish_out(3, exp_re, '0);

        // T5: reset in the MAC phase of row 2.
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t5_busy", bus.busy, 1'b0);
        check("t5_div_req", bus.div_req, 1'b0);
        check("t5_x_valid", bus.x_valid, 1'b0);
        check("t5_x_real", bus.x_real, '0);
        check("t5_div_num", {bus.div_num_real, bus.div_num_imag}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        load_all();
        run_solve(-1, lat);
        check("t5_rerun_latency", lat, 14);
        check("t5_rerun_x_real", bus.x_real, exp_re);
        finish_out(0, exp_re, '0);

        // T6: start and a write to R11 while busy are ignored.
        run_solve(3, lat);
        check("t6_latency", lat, 14);
        check("t6_x_real", bus.x_real, exp_re);
        check("t6_x_imag", bus.x_imag, '0);
        finish_out(0, exp_re, '0);
        run_solve(-1, lat);
        check("t6_r11_kept", bus.x_real, exp_re);
        check("t6_r11_kept_imag", bus.x_imag, '0);
        finish_out(0, exp_re, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
